// File: rtl/audiodac_rd_sched_if.sv
// FIFO read port and modulator sample port of the audio DAC read scheduler.
// The master drives the read strobe and the held sample; the slave side is FIFO plus modulator.
interface audiodac_rd_sched_if #(
  parameter int AUDIO_WIDTH = 16
);
  // audio_rd pops one word; the word appears on audio_data one cycle later.
  // sample_valid is a one-cycle pulse marking the cycle in which sample has just been updated;
  // there is no back-pressure on either strobe.
  logic                   audio_rd;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [AUDIO_WIDTH-1:0] audio_data;
  logic [AUDIO_WIDTH-1:0] sample;
  logic                   sample_valid;

  modport master (
    output audio_rd, sample, sample_valid,
    input  fifo_empty, fifo_full, audio_data
  );

  modport slave (
    input  audio_rd, sample, sample_valid,
    output fifo_empty, fifo_full, audio_data
  );
endinterface

// File: rtl/audiodac_rd_sched.sv
// Audio DAC read scheduler: sample-rate divider, FIFO priming, read strobes, underrun
// detection and the midscale-substituting sample hold for the modulator.
module audiodac_rd_sched #(
  parameter int AUDIO_WIDTH = 16,
  parameter int DIV_WIDTH   = 12,
  parameter int PRIME_TICKS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_i,
  input  logic [DIV_WIDTH-1:0] rate_div_i,
  input  logic                 clr_i,
  audiodac_rd_sched_if.master  bus,
  output logic                 tick_o,
  output logic                 running_o,
  output logic                 underrun_o,
  output logic [7:0]           underrun_cnt_o,
  output logic [1:0]           state_o
);

  localparam int PW = $clog2(PRIME_TICKS + 1);
  localparam logic [AUDIO_WIDTH-1:0] MIDSCALE   = {1'b1, {(AUDIO_WIDTH-1){1'b0}}};
  localparam logic [PW-1:0]          PRIME_LAST = PW'(PRIME_TICKS - 1);
  localparam logic [DIV_WIDTH-1:0]   DIV_MIN    = DIV_WIDTH'(3);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e                 state_q;
  logic [DIV_WIDTH-1:0]   div_cnt_q;
  logic [PW-1:0]          prime_cnt_q;
  logic                   tick_q;
  logic                   rd_q;
  logic                   cap_q;
  logic [AUDIO_WIDTH-1:0] sample_q;
  logic                   sample_valid_q;
  logic                   underrun_q;
  logic [7:0]             underrun_cnt_q;

  logic [DIV_WIDTH-1:0]   div_reload;
  logic [7:0]             underrun_cnt_d;

  // A divider below 3 would let a tick land before the previous capture finished.
  assign div_reload     = (rate_div_i < DIV_MIN) ? DIV_MIN : rate_div_i;
  assign underrun_cnt_d = clr_i ? 8'd1 :
                          (underrun_cnt_q == 8'hFF) ? 8'hFF : underrun_cnt_q + 8'd1;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q        <= ST_IDLE;
      div_cnt_q      <= '0;
      prime_cnt_q    <= '0;
      tick_q         <= 1'b0;
      rd_q           <= 1'b0;
      cap_q          <= 1'b0;
      sample_q       <= MIDSCALE;
      sample_valid_q <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      tick_q         <= 1'b0;
      rd_q           <= 1'b0;
      cap_q          <= rd_q;
      sample_valid_q <= 1'b0;
      if (clr_i) begin
        underrun_q     <= 1'b0;
        underrun_cnt_q <= '0;
      end
      if (!enable_i) begin
        state_q     <= ST_IDLE;
        div_cnt_q   <= '0;
        prime_cnt_q <= '0;
        sample_q    <= MIDSCALE;
      end else begin
        if (state_q != ST_IDLE) begin
          if (div_cnt_q == '0) begin
            tick_q    <= 1'b1;
            div_cnt_q <= div_reload;
          end else begin
            div_cnt_q <= div_cnt_q - DIV_WIDTH'(1);
          end
        end
        // A capture that outlived a disable never reaches RUN here, so it is dropped.
        if (cap_q && state_q == ST_RUN) begin
          sample_q       <= bus.audio_data;
          sample_valid_q <= 1'b1;
        end
        case (state_q)
          ST_IDLE: begin
            state_q     <= ST_PRIME;
            div_cnt_q   <= div_reload;
            prime_cnt_q <= '0;
            sample_q    <= MIDSCALE;
          end
          ST_PRIME: begin
            if (tick_q) begin
              prime_cnt_q <= bus.fifo_empty ? '0 : prime_cnt_q + PW'(1);
            end
            if (bus.fifo_full || (tick_q && !bus.fifo_empty && prime_cnt_q == PRIME_LAST)) begin
              state_q <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (tick_q) begin
              if (!bus.fifo_empty) begin
                rd_q <= 1'b1;
              end else begin
                state_q        <= ST_PRIME;
                prime_cnt_q    <= '0;
                sample_q       <= MIDSCALE;
                sample_valid_q <= 1'b1;
                underrun_q     <= 1'b1;
                underrun_cnt_q <= underrun_cnt_d;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.audio_rd     = rd_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = sample_valid_q;
  assign tick_o           = tick_q;
  assign running_o        = (state_q == ST_RUN);
  assign underrun_o       = underrun_q;
  assign underrun_cnt_o   = underrun_cnt_q;
  assign state_o          = state_q;

endmodule

// File: doc/audiodac_rd_sched.md
# audiodac_rd_sched

Read scheduler for the audio DAC sample FIFO. It divides the system clock down to the audio sample rate and issues one-cycle read strobes to the FIFO read port. It primes the FIFO before playback and detects underruns. It also holds the sample presented to the delta-sigma modulator, substituting unsigned midscale whenever no valid audio is available. It sits between the FIFO read side and the modulator input, in the same clock domain as the FIFO.

## Interface
- AUDIO_WIDTH, 16, sample width; unsigned, midscale = {1'b1, zeros}
- DIV_WIDTH, 12, width of the rate divider value
- PRIME_TICKS, 4, consecutive non-empty sample ticks required before playback starts (≥1)
- clk_i  in  1  system clock; all logic on posedge
- rst_n_i  in  1  reset; synchronous, active-low
- enable_i  in  1  scheduler enable; low forces IDLE
- rate_div_i  in  DIV_WIDTH  sample period minus 1, in clk_i cycles; values <3 are treated as 3
- clr_i  in  1  clears the underrun flag and counter
- fifo_empty_i  in  1  FIFO empty flag (combinational from FIFO pointers)
- fifo_full_i  in  1  FIFO full flag
- audio_data_i  in  AUDIO_WIDTH  FIFO output word at the current read pointer
- audio_rd_o  out  1  one-cycle read strobe to the FIFO
- sample_o  out  AUDIO_WIDTH  sample held for the modulator
- sample_valid_o  out  1  one-cycle pulse when sample_o updates
- tick_o  out  1  one-cycle sample-rate tick
- running_o  out  1  high in RUN
- underrun_o  out  1  sticky underrun flag
- underrun_cnt_o  out  8  saturating underrun count
- state_o  out  2  IDLE=0, PRIME=1, RUN=2

## Operation
- **Reset (rst_n_i low at posedge).** All outputs go to 0, except sample_o, which goes to midscale (16'h8000 at default width). State = IDLE. Divider counter = 0.
- **Divider.**
  - Counts down only in PRIME and RUN.
  - When the counter reaches 0, tick_o pulses for one cycle and the counter reloads with max(rate_div_i, 3).
  - rate_div_i is sampled only at reload.
  - On entry to PRIME from IDLE, the counter loads max(rate_div_i, 3).
- **IDLE.**
  - audio_rd_o = 0 and sample_o = midscale.
  - Leaves for PRIME when enable_i = 1.
- **PRIME.**
  - A prime counter increments on each tick with fifo_empty_i = 0 and clears on each tick with fifo_empty_i = 1.
  - Transitions to RUN on the tick where the count reaches PRIME_TICKS, or on the first cycle fifo_full_i = 1 (whichever comes first).
  - No reads in PRIME. sample_o stays midscale.
- **RUN.**
  - On a tick with fifo_empty_i = 0, assert audio_rd_o for the next cycle.
  - On a tick with fifo_empty_i = 1 (underrun):
    - no read;
    - sample_o <= midscale and sample_valid_o pulses;
    - underrun_o <= 1;
    - underrun_cnt_o increments, saturating at 255;
    - state <= PRIME with the prime counter cleared.
- **Read capture.** The FIFO read pointer advances at the edge ending the audio_rd_o cycle. audio_data_i is therefore the new sample one cycle later. sample_o loads audio_data_i at the edge ending the cycle after audio_rd_o, and sample_valid_o is high in the cycle following that load.
- **enable_i low (any state).** At the next edge:
  - state goes to IDLE;
  - divider and prime counters clear;
  - audio_rd_o goes to 0;
  - sample_o goes to midscale;
  - any read already issued still completes its capture but is discarded (sample_o stays midscale, no sample_valid_o).
  - underrun_o and underrun_cnt_o are retained.
- **clr_i.** Clears underrun_o and underrun_cnt_o. If an underrun event occurs in the same cycle, the event wins: flag = 1, count = 1.
- **Reset mid-operation.** Behaves exactly as reset from power-up; no pending read completes.

## Timing
- audio_rd_o is registered: high in cycle T+1 for a tick in cycle T. It is never high in two consecutive cycles.
- Tick-to-sample_valid_o latency: 3 cycles (tick at T, rd at T+1, capture edge ending T+2, valid at T+3).
- Minimum tick spacing is 4 cycles, so captures never overlap.
- Underrun: sample_o = midscale and sample_valid_o are seen in cycle T+1 for a tick at T.
- PRIME→RUN on full: state_o = 2 in the cycle after fifo_full_i is seen high. The first read occurs on the next tick.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
- **Reset:** hold rst_n_i = 0 for 3 cycles with enable_i = 1 → state_o = 0, sample_o = 16'h8000, audio_rd_o = 0, underrun_cnt_o = 0.
- **Nominal playback:** rate_div_i = 9, FIFO model preloaded with 8 words 16'h1000..16'h1007, enable_i = 1 → RUN after 4 ticks; then audio_rd_o every 10 cycles; sample_o = 16'h1000, 16'h1001, …, with valid 3 cycles after each tick.
- **Underrun:** FIFO drains during RUN → midscale plus valid on the tick after the last word; underrun_o = 1; count = 1; state_o = 1. After 4 non-empty ticks → RUN resumes.
- **Early start on full:** assert fifo_full_i in PRIME after 1 tick → state_o = 2 in the next cycle.
- **Divider clamp and clear priority:** rate_div_i = 0 → ticks every 4 cycles. Assert clr_i in the same cycle as an underrun → underrun_o = 1, underrun_cnt_o = 1. Force 300 underruns → count saturates at 255.
- **Disable mid-read:** drop enable_i in the audio_rd_o cycle → IDLE next cycle, sample_o stays 16'h8000, no sample_valid_o pulse.
